// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared BCD types, limits and helpers for the time keeper
package time_pkg;

    typedef logic [7:0] bcd_pair_t;

    localparam bcd_pair_t SEC_MAX = 8'h59;
    localparam bcd_pair_t MIN_MAX = 8'h59;

    // True when both nibbles are decimal digits
    function automatic logic bcd_is_valid(input bcd_pair_t v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Converts a small binary constant (0..99) to a BCD pair
    function automatic bcd_pair_t to_bcd(input int v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'((v / 10) % 10);
        ones = 4'(v % 10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD counter wrapping at a programmable limit
module bcd_mod_counter
    import time_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic [7:0] max_val,
    output logic [7:0] q,
    output logic       wrap
);

    // Carry out to the next stage; the top registers it before it leaves the block
    assign wrap = inc & (q == max_val);

    // Count register: load wins over increment, ones digit carries into tens
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= 8'h00;
        end else if (load) begin
            q <= load_val;
        end else if (inc) begin
            if (q == max_val) begin
                q <= 8'h00;
            end else if (q[3:0] == 4'd9) begin
                q <= {q[7:4] + 4'd1, 4'h0};
            end else begin
                q <= {q[7:4], q[3:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - hh:mm:ss BCD wall clock driven by a sampled 1 Hz square wave
module time_keeper
    import time_pkg::*;
#(
    parameter int HR_MAX = 23
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       run,
    input  logic       load_en,
    input  logic [7:0] load_hr,
    input  logic [7:0] load_min,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hr_bcd,
    output logic       sec_pulse,
    output logic       min_wrap,
    output logic       day_wrap,
    output logic       load_err
);

    localparam bcd_pair_t HR_MAX_BCD = to_bcd(HR_MAX);

    logic tick_q;
    logic rise;
    logic count;
    logic load_ok;
    logic load_go;
    logic sec_wrap_c;
    logic min_wrap_c;
    logic hr_wrap_c;

    assign rise    = tick_in & ~tick_q;
    // A load in the same cycle swallows the tick rather than deferring it
    assign count   = rise & run & ~load_en;
    assign load_ok = bcd_is_valid(load_hr) && bcd_is_valid(load_min) &&
                     (load_min <= MIN_MAX) && (load_hr <= HR_MAX_BCD);
    assign load_go = load_en & load_ok;

    // Edge detector history; resets high so a level already high at release is not counted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q <= 1'b1;
        end else begin
            tick_q <= tick_in;
        end
    end

    bcd_mod_counter u_sec (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (count),
        .load     (load_go),
        .load_val (8'h00),
        .max_val  (SEC_MAX),
        .q        (sec_bcd),
        .wrap     (sec_wrap_c)
    );

    bcd_mod_counter u_min (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (sec_wrap_c),
        .load     (load_go),
        .load_val (load_min),
        .max_val  (MIN_MAX),
        .q        (min_bcd),
        .wrap     (min_wrap_c)
    );

    bcd_mod_counter u_hr (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (min_wrap_c),
        .load     (load_go),
        .load_val (load_hr),
        .max_val  (HR_MAX_BCD),
        .q        (hr_bcd),
        .wrap     (hr_wrap_c)
    );

    // Registered strobes so downstream sees them aligned with the new counter values
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sec_pulse <= 1'b0;
            min_wrap  <= 1'b0;
            day_wrap  <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            sec_pulse <= count;
            min_wrap  <= sec_wrap_c;
            day_wrap  <= hr_wrap_c;
            load_err  <= load_en & ~load_ok;
        end
    end

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - self-checking bench for time_keeper against a seconds-of-day model
module tb_time_keeper;

    localparam int HR_MAX = 23;
    localparam int DAY    = (HR_MAX + 1) * 3600;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_in = 1'b0;
    logic       run = 1'b1;
    logic       load_en = 1'b0;
    logic [7:0] load_hr = 8'h00;
    logic [7:0] load_min = 8'h00;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic [7:0] hr_bcd;
    logic       sec_pulse;
    logic       min_wrap;
    logic       day_wrap;
    logic       load_err;

    time_keeper #(.HR_MAX(HR_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_in   (tick_in),
        .run       (run),
        .load_en   (load_en),
        .load_hr   (load_hr),
        .load_min  (load_min),
        .sec_bcd   (sec_bcd),
        .min_bcd   (min_bcd),
        .hr_bcd    (hr_bcd),
        .sec_pulse (sec_pulse),
        .min_wrap  (min_wrap),
        .day_wrap  (day_wrap),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Reference state: time as seconds since midnight, plus the last sampled tick level
    int model_s   = 0;
    bit prev_tick = 1'b1;
    bit e_sp, e_mw, e_dw, e_le;

    function automatic logic [7:0] bcd2(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance the model on the current inputs, clock once, then compare everything
    task automatic cyc();
        bit rise;
        bit ok;
        int hr;
        int mn;
        rise = tick_in && !prev_tick;
        e_sp = 0; e_mw = 0; e_dw = 0; e_le = 0;
        if (!rst_n) begin
            model_s   = 0;
            prev_tick = 1'b1;
        end else begin
            if (load_en) begin
                ok = (load_hr[7:4] <= 9) && (load_hr[3:0] <= 9) &&
                     (load_min[7:4] <= 9) && (load_min[3:0] <= 9);
                hr = int'(load_hr[7:4]) * 10 + int'(load_hr[3:0]);
                mn = int'(load_min[7:4]) * 10 + int'(load_min[3:0]);
                ok = ok && (hr <= HR_MAX) && (mn <= 59);
                if (ok) model_s = hr * 3600 + mn * 60;
                else    e_le = 1;
            end else if (rise && run) begin
                e_sp    = 1;
                model_s = model_s + 1;
                if (model_s % 60 == 0) e_mw = 1;
                if (model_s == DAY) begin
                    model_s = 0;
                    e_dw    = 1;
                end
            end
            prev_tick = tick_in;
        end
        @(posedge clk);
        #1;
        chk("sec_bcd", sec_bcd, bcd2(model_s % 60));
        chk("min_bcd", min_bcd, bcd2((model_s / 60) % 60));
        chk("hr_bcd", hr_bcd, bcd2(model_s / 3600));
        chk("sec_pulse", {7'b0, sec_pulse}, {7'b0, e_sp});
        chk("min_wrap", {7'b0, min_wrap}, {7'b0, e_mw});
        chk("day_wrap", {7'b0, day_wrap}, {7'b0, e_dw});
        chk("load_err", {7'b0, load_err}, {7'b0, e_le});
    endtask

    task automatic rises(input int n);
        repeat (n) begin
            tick_in = 1'b0; cyc();
            tick_in = 1'b1; cyc();
        end
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m);
        load_hr  = h;
        load_min = m;
        load_en  = 1'b1;
        cyc();
        load_en  = 1'b0;
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();

        // Three counts from reset
        rises(3);
        chk("t3_sec", sec_bcd, 8'h03);
        chk("t3_min", min_bcd, 8'h00);

        // Day rollover from 23:59
        do_load(8'h23, 8'h59);
        rises(60);
        chk("roll_hr", hr_bcd, 8'h00);
        chk("roll_min", min_bcd, 8'h00);
        chk("roll_sec", sec_bcd, 8'h00);

        // Rejected loads leave time alone
        do_load(8'h05, 8'h07);
        do_load(8'h12, 8'h60);
        do_load(8'h1A, 8'h00);
        do_load(8'h24, 8'h00);
        chk("rej_hr", hr_bcd, 8'h05);
        chk("rej_min", min_bcd, 8'h07);

        // Load coincident with a rising tick: load wins, tick is dropped
        do_load(8'h00, 8'h00);
        rises(5);
        tick_in  = 1'b0; cyc();
        tick_in  = 1'b1;
        load_hr  = 8'h10;
        load_min = 8'h30;
        load_en  = 1'b1;
        cyc();
        load_en  = 1'b0;
        chk("coinc_hr", hr_bcd, 8'h10);
        chk("coinc_min", min_bcd, 8'h30);
        chk("coinc_sec", sec_bcd, 8'h00);
        chk("coinc_pulse", {7'b0, sec_pulse}, 8'h00);

        // Paused, then resumed
        run = 1'b0;
        rises(5);
        chk("pause_sec", sec_bcd, 8'h00);
        run = 1'b1;
        rises(1);
        chk("resume_sec", sec_bcd, 8'h01);

        // Tick held high across reset release
        tick_in = 1'b1;
        rst_n   = 1'b0;
        repeat (2) cyc();
        rst_n   = 1'b1;
        repeat (3) cyc();
        chk("hold_sec", sec_bcd, 8'h00);
        tick_in = 1'b0; cyc();
        tick_in = 1'b1; cyc();
        chk("hold_sec2", sec_bcd, 8'h01);

        // Reset in the middle of counting
        do_load(8'h01, 8'h02);
        rises(3);
        chk("pre_rst_sec", sec_bcd, 8'h03);
        tick_in = 1'b0;
        rst_n   = 1'b0;
        cyc();
        chk("mid_rst_hr", hr_bcd, 8'h00);
        chk("mid_rst_min", min_bcd, 8'h00);
        chk("mid_rst_sec", sec_bcd, 8'h00);
        rst_n = 1'b1;
        cyc();

        // Randomised traffic against the model
        repeat (3000) begin
            tick_in = 1'($urandom_range(0, 1));
            run     = ($urandom_range(0, 9) != 0);
            load_en = ($urandom_range(0, 49) == 0);
            rst_n   = ($urandom_range(0, 499) != 0);
            case ($urandom_range(0, 2))
                0: begin
                    load_hr  = 8'($urandom_range(0, 255));
                    load_min = 8'($urandom_range(0, 255));
                end
                1: begin
                    load_hr  = bcd2($urandom_range(0, HR_MAX));
                    load_min = bcd2($urandom_range(0, 59));
                end
                default: begin
                    load_hr  = bcd2(HR_MAX);
                    load_min = 8'h59;
                end
            endcase
            cyc();
        end
        rst_n   = 1'b1;
        load_en = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
